// File: rtl/sdram_device_model.sv
// sdram_device_model
//   Device-side responder for the SDR SDRAM pins of FullSystemTop. It decodes
//   controller commands, tracks open rows per bank, honours the mode register
//   (burst length, CAS latency, single-location writes), keeps data in an
//   on-chip array and returns read bursts with CAS-latency timing.
//
//   Optional build macro: SDRAM_MODEL_CHECK_EN enables the sticky protocol
//   checker. Without it io_protocol_err is tied to 0.
//
//   Ports
//     clock, i_reset            clock, asynchronous active-low reset
//     io_sdram_addr/bank        address (A10 = auto/all-bank precharge), bank
//     io_sdram_dataOut          write data from the controller
//     io_sdram_output_en        controller drives DQ (checked for contention)
//     io_sdram_dqm              byte masks (write latency 0, read latency 2)
//     io_sdram_cke/cs_n/ras_n/cas_n/we_n   command pins
//     io_dqIn, io_dq_oe         read data and its valid/drive strobe
//     io_protocol_err           sticky violation flag
//     io_refresh_count          AUTO REFRESH counter (wraps)
module sdram_device_model #(
    parameter int CAS_LATENCY    = 2,
    parameter int COL_BITS       = 9,
    parameter int ROW_STORE_BITS = 1,
    parameter int TRCD           = 2
) (
    input  logic        clock,
    input  logic        i_reset,
    input  logic [12:0] io_sdram_addr,
    input  logic [1:0]  io_sdram_bank,
    input  logic [31:0] io_sdram_dataOut,
    input  logic        io_sdram_output_en,
    input  logic [3:0]  io_sdram_dqm,
    input  logic        io_sdram_cke,
    input  logic        io_sdram_cs_n,
    input  logic        io_sdram_ras_n,
    input  logic        io_sdram_cas_n,
    input  logic        io_sdram_we_n,
    output logic [31:0] io_dqIn,
    output logic        io_dq_oe,
    output logic        io_protocol_err,
    output logic [15:0] io_refresh_count
);
    localparam int IDX_W = 2 + ROW_STORE_BITS + COL_BITS;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
    } cmd_e;

    // Low-bit mask of a burst: the column bits that wrap inside the burst.
    function automatic logic [2:0] burst_mask(input logic [1:0] code);
        case (code)
            2'd0:    burst_mask = 3'd0;
            2'd1:    burst_mask = 3'd1;
            2'd2:    burst_mask = 3'd3;
            default: burst_mask = 3'd7;
        endcase
    endfunction

    function automatic logic [COL_BITS-1:0] wrap_col(input logic [COL_BITS-1:0] col,
                                                     input logic [2:0] mask);
        logic [COL_BITS-1:0] m;
        m = COL_BITS'(mask);
        wrap_col = (col & ~m) | ((col + COL_BITS'(1)) & m);
    endfunction

    function automatic logic [31:0] dqm_bits(input logic [3:0] m);
        for (int i = 0; i < 4; i++) dqm_bits[8*i +: 8] = {8{m[i]}};
    endfunction

    logic [31:0]               mem_q [DEPTH];
    logic [3:0]                bank_open_q, bank_open_d;
    logic [ROW_STORE_BITS-1:0] bank_row_q [4];
    logic [ROW_STORE_BITS-1:0] bank_row_d [4];
    logic [1:0]                mode_bl_q, mode_bl_d;
    logic                      mode_cl3_q, mode_cl3_d, mode_ws_q, mode_ws_d;
    logic [2:0]                gen_rem_q, gen_rem_d, gen_mask_q, gen_mask_d;
    logic [COL_BITS-1:0]       gen_col_q, gen_col_d;
    logic [1:0]                gen_bank_q, gen_bank_d;
    logic [ROW_STORE_BITS-1:0] gen_row_q, gen_row_d;
    logic                      gen_wr_q, gen_wr_d, gen_ap_q, gen_ap_d, gen_cl3_q, gen_cl3_d;
    logic                      vld_p1_q, vld_p2_q;
    logic [31:0]               dat_p1_q, dat_p2_q;
    logic [3:0]                dqm_q;
    logic [31:0]               dq_q;
    logic                      oe_q;
    logic [15:0]               refresh_q;

    cmd_e                      cmd;
    logic                      cmd_rw, gen_stop, gen_issue, a10;
    logic [2:0]                cmd_mask;
    logic                      iss_vld, iss_wr, iss_cl3, iss_ap_last;
    logic [1:0]                iss_bank;
    logic [ROW_STORE_BITS-1:0] iss_row;
    logic [COL_BITS-1:0]       iss_col;
    logic [IDX_W-1:0]          iss_idx;
    logic [31:0]               rd_word;
    logic                      iss_rd;

    logic unused_ok;
    assign unused_ok = ^{io_sdram_addr[12:11], io_sdram_output_en};

    assign a10 = io_sdram_addr[10];

    always_comb begin
        cmd = CMD_NOP;
        if (io_sdram_cke && !io_sdram_cs_n)
            cmd = cmd_e'({io_sdram_ras_n, io_sdram_cas_n, io_sdram_we_n});
    end

    assign cmd_rw    = (cmd == CMD_RD) || (cmd == CMD_WR);
    // Single-location write mode shortens write bursts to one word only.
    assign cmd_mask  = burst_mask((cmd == CMD_WR && mode_ws_q) ? 2'd0 : mode_bl_q);
    assign gen_stop  = cmd_rw || (cmd == CMD_BST) ||
                       ((cmd == CMD_PRE) && (a10 || io_sdram_bank == gen_bank_q));
    assign gen_issue = io_sdram_cke && (gen_rem_q != 3'd0) && !gen_stop;

    // A new command issues its first column in its own cycle; the generator
    // supplies the rest of the burst.
    assign iss_vld     = cmd_rw || gen_issue;
    assign iss_wr      = cmd_rw ? (cmd == CMD_WR)                  : gen_wr_q;
    assign iss_bank    = cmd_rw ? io_sdram_bank                    : gen_bank_q;
    assign iss_row     = cmd_rw ? bank_row_q[io_sdram_bank]        : gen_row_q;
    assign iss_col     = cmd_rw ? io_sdram_addr[COL_BITS-1:0]      : gen_col_q;
    assign iss_cl3     = cmd_rw ? mode_cl3_q                       : gen_cl3_q;
    assign iss_ap_last = cmd_rw ? (a10 && cmd_mask == 3'd0)        : (gen_ap_q && gen_rem_q == 3'd1);
    assign iss_idx     = {iss_bank, iss_row, iss_col};
    assign rd_word     = mem_q[iss_idx];
    assign iss_rd      = iss_vld && !iss_wr;

    always_comb begin
        gen_rem_d  = gen_rem_q;  gen_mask_d = gen_mask_q; gen_col_d = gen_col_q;
        gen_bank_d = gen_bank_q; gen_row_d  = gen_row_q;  gen_wr_d  = gen_wr_q;
        gen_ap_d   = gen_ap_q;   gen_cl3_d  = gen_cl3_q;
        if (cmd_rw) begin
            gen_rem_d  = cmd_mask;
            gen_mask_d = cmd_mask;
            gen_col_d  = wrap_col(io_sdram_addr[COL_BITS-1:0], cmd_mask);
            gen_bank_d = io_sdram_bank;
            gen_row_d  = bank_row_q[io_sdram_bank];
            gen_wr_d   = (cmd == CMD_WR);
            gen_ap_d   = a10;
            gen_cl3_d  = mode_cl3_q;
        end else if (gen_stop) begin
            gen_rem_d = 3'd0;
        end else if (gen_issue) begin
            gen_rem_d = gen_rem_q - 3'd1;
            gen_col_d = wrap_col(gen_col_q, gen_mask_q);
        end
    end

    always_comb begin
        bank_open_d = bank_open_q;
        bank_row_d  = bank_row_q;
        mode_bl_d   = mode_bl_q;
        mode_cl3_d  = mode_cl3_q;
        mode_ws_d   = mode_ws_q;
        if (cmd == CMD_ACT) begin
            bank_open_d[io_sdram_bank] = 1'b1;
            bank_row_d[io_sdram_bank]  = io_sdram_addr[ROW_STORE_BITS-1:0];
        end
        if (cmd == CMD_PRE) begin
            if (a10) bank_open_d = 4'b0000;
            else     bank_open_d[io_sdram_bank] = 1'b0;
        end
        if (iss_vld && iss_ap_last) bank_open_d[iss_bank] = 1'b0;
        if (cmd == CMD_LMR) begin
            mode_bl_d  = io_sdram_addr[2] ? 2'd0 : io_sdram_addr[1:0];
            mode_cl3_d = (io_sdram_addr[6:4] == 3'd3);
            mode_ws_d  = io_sdram_addr[9];
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            bank_open_q <= '0;
            for (int b = 0; b < 4; b++) bank_row_q[b] <= '0;
            mode_bl_q  <= 2'd0;
            mode_cl3_q <= (CAS_LATENCY == 3);
            mode_ws_q  <= 1'b0;
            gen_rem_q  <= '0; gen_mask_q <= '0; gen_col_q <= '0; gen_bank_q <= '0;
            gen_row_q  <= '0; gen_wr_q   <= 1'b0; gen_ap_q <= 1'b0; gen_cl3_q <= 1'b0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            dqm_q      <= '0;
            dq_q       <= '0;
            oe_q       <= 1'b0;
            refresh_q  <= '0;
        end else if (io_sdram_cke) begin
            bank_open_q <= bank_open_d;
            bank_row_q  <= bank_row_d;
            mode_bl_q   <= mode_bl_d;
            mode_cl3_q  <= mode_cl3_d;
            mode_ws_q   <= mode_ws_d;
            gen_rem_q   <= gen_rem_d;  gen_mask_q <= gen_mask_d; gen_col_q <= gen_col_d;
            gen_bank_q  <= gen_bank_d; gen_row_q  <= gen_row_d;  gen_wr_q  <= gen_wr_d;
            gen_ap_q    <= gen_ap_d;   gen_cl3_q  <= gen_cl3_d;
            if (cmd == CMD_REF) refresh_q <= refresh_q + 16'd1;
            // p1: CL=3 entries wait here one extra cycle
            vld_p1_q <= iss_rd && iss_cl3;
            // p2: CL=2 entries enter directly; CL=3 entries arrive from p1
            vld_p2_q <= (iss_rd && !iss_cl3) || vld_p1_q;
            // output: read DQM sampled one cycle earlier gives latency 2
            dqm_q    <= io_sdram_dqm;
            oe_q     <= vld_p2_q;
            dq_q     <= vld_p2_q ? (dat_p2_q & ~dqm_bits(dqm_q)) : 32'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (io_sdram_cke) begin
            dat_p1_q <= rd_word;
            dat_p2_q <= (iss_rd && !iss_cl3) ? rd_word : dat_p1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset && io_sdram_cke && iss_vld && iss_wr) begin
            for (int b = 0; b < 4; b++)
                if (!io_sdram_dqm[b]) mem_q[iss_idx][8*b +: 8] <= io_sdram_dataOut[8*b +: 8];
        end
    end

    assign io_dqIn          = dq_q;
    assign io_dq_oe         = oe_q;
    assign io_refresh_count = refresh_q;

`ifdef SDRAM_MODEL_CHECK_EN
    logic [7:0] since_act_q [4];
    logic [7:0] since_act_d [4];
    logic       err_q, err_d;

    always_comb begin
        err_d = err_q;
        for (int b = 0; b < 4; b++)
            since_act_d[b] = (since_act_q[b] == 8'hFF) ? 8'hFF : since_act_q[b] + 8'd1;
        if (cmd == CMD_ACT) begin
            since_act_d[io_sdram_bank] = 8'd1;
            if (bank_open_q[io_sdram_bank]) err_d = 1'b1;
        end
        if (cmd_rw && (!bank_open_q[io_sdram_bank] || int'(since_act_q[io_sdram_bank]) < TRCD))
            err_d = 1'b1;
        if ((cmd == CMD_REF || cmd == CMD_LMR) && (bank_open_q != 4'b0000)) err_d = 1'b1;
        if (cmd == CMD_LMR && ((io_sdram_addr[2:0] > 3'd3) ||
            (io_sdram_addr[6:4] != 3'd2 && io_sdram_addr[6:4] != 3'd3)))
            err_d = 1'b1;
        if (io_sdram_output_en && oe_q) err_d = 1'b1;
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            err_q <= 1'b0;
            for (int b = 0; b < 4; b++) since_act_q[b] <= '0;
        end else if (io_sdram_cke) begin
            err_q       <= err_d;
            since_act_q <= since_act_d;
        end
    end

    assign io_protocol_err = err_q;
`else
    assign io_protocol_err = 1'b0;
`endif
endmodule
